snake_control: RTL and testbench

SNAKE_CONTROL -- requirements
Module: snake_control

---
 rtl/snake_pkg.sv | 42 ++++
 rtl/Generic_Counter.sv | 41 ++++
 rtl/snake_control.sv | 151 +++++++++++++++
 tb/tb_snake_control.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game: grid geometry, direction and game-state
// encodings, pixel colours and the (x,y) cell record used for body segments.
package snake_pkg;

    localparam int GRID_W     = 80;
    localparam int GRID_H     = 60;
    localparam int CELL_SHIFT = 3;
    localparam int START_X    = 40;
    localparam int START_Y    = 30;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        GAME_IDLE = 2'b00,
        GAME_PLAY = 2'b01,
        GAME_WIN  = 2'b10,
        GAME_LOSE = 2'b11
    } game_e;

    localparam logic [11:0] COLOUR_IDLE   = 12'h000;
    localparam logic [11:0] COLOUR_WIN    = 12'h0F0;
    localparam logic [11:0] COLOUR_LOSE   = 12'hF00;
    localparam logic [11:0] COLOUR_SNAKE  = 12'hFF0;
    localparam logic [11:0] COLOUR_TARGET = 12'hF00;
    localparam logic [11:0] COLOUR_BG     = 12'h00F;

    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
    } cell_t;

    // Opposite headings differ only in the upper encoding bit.
    function automatic dir_e reverse_dir(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/Generic_Counter.sv
// Free-running modulo counter: counts while ENABLE_IN is high, holds otherwise,
// and raises TRIG_OUT for the enabled cycle in which it wraps from COUNTER_MAX.
module Generic_Counter #(
    parameter int COUNTER_WIDTH = 4,
    parameter int COUNTER_MAX   = 9
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE_IN,
    output logic TRIG_OUT
);

    localparam logic [COUNTER_WIDTH-1:0] MAX_V = COUNTER_WIDTH'(COUNTER_MAX);

    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     trig;

    always_comb begin
        count_d = count_q;
        trig    = 1'b0;
        if (ENABLE_IN) begin
            if (count_q == MAX_V) begin
                count_d = '0;
                trig    = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign TRIG_OUT = trig;

endmodule

// File: rtl/snake_control.sv
// Snake body, movement, collision/target detection and pixel colouring.
// Define SNAKE_WRAP_EN to make the head wrap at the grid edges instead of failing.
module snake_control
    import snake_pkg::*;
#(
    parameter int MAX_LEN     = 32,
    parameter int INIT_LEN    = 4,
    parameter int MOVE_PERIOD = 10_000_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [9:0]  ADDRH,
    input  logic [8:0]  ADDRV,
    input  logic [1:0]  MASTER_STATE,
    input  logic [1:0]  DIRECTION,
    input  logic [6:0]  TARGET_X,
    input  logic [5:0]  TARGET_Y,
    output logic [11:0] COLOUR_OUT,
    output logic        TARGET_REACHED,
    output logic        FAILED
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_W = $clog2(MOVE_PERIOD);
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    cell_t            seg_q [MAX_LEN];
    cell_t            seg_d [MAX_LEN];
    logic [LEN_W-1:0] len_q, len_d;
    dir_e             heading_q, heading_d, heading_next;
    logic [11:0]      colour_q, colour_d;
    logic             hit_q, hit_d, fail_q, fail_d;

    game_e game;
    logic  play, tick, at_edge, collide, on_body;
    cell_t head, new_head, target, pix_cell;
    logic  unused_addr_bits;

    assign game             = game_e'(MASTER_STATE);
    assign play             = (game == GAME_PLAY);
    assign target           = '{x: TARGET_X, y: TARGET_Y};
    assign pix_cell         = '{x: ADDRH[9:CELL_SHIFT], y: ADDRV[8:CELL_SHIFT]};
    assign unused_addr_bits = ^{ADDRH[CELL_SHIFT-1:0], ADDRV[CELL_SHIFT-1:0]};

    Generic_Counter #(
        .COUNTER_WIDTH (CNT_W),
        .COUNTER_MAX   (MOVE_PERIOD - 1)
    ) u_step_counter (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE_IN (play),
        .TRIG_OUT  (tick)
    );

    // Candidate head for the next step; at_edge flags a step off the grid.
    always_comb begin
        heading_next = (dir_e'(DIRECTION) == reverse_dir(heading_q)) ? heading_q : dir_e'(DIRECTION);
        head     = seg_q[0];
        new_head = head;
        at_edge  = 1'b0;
        case (heading_next)
            DIR_UP:
                if (head.y == '0) begin
                    at_edge = 1'b1; new_head.y = 6'(GRID_H - 1);
                end else new_head.y = head.y - 1'b1;
            DIR_DOWN:
                if (head.y == 6'(GRID_H - 1)) begin
                    at_edge = 1'b1; new_head.y = '0;
                end else new_head.y = head.y + 1'b1;
            DIR_LEFT:
                if (head.x == '0) begin
                    at_edge = 1'b1; new_head.x = 7'(GRID_W - 1);
                end else new_head.x = head.x - 1'b1;
            DIR_RIGHT:
                if (head.x == 7'(GRID_W - 1)) begin
                    at_edge = 1'b1; new_head.x = '0;
                end else new_head.x = head.x + 1'b1;
        endcase
        // The current tail vacates its cell on this step, so it cannot be hit.
        collide = 1'b0;
        for (int i = 0; i < MAX_LEN - 1; i++) begin
            if ((i < int'(len_q) - 1) && (seg_q[i] == new_head)) collide = 1'b1;
        end
    end

    always_comb begin
        seg_d     = seg_q;
        len_d     = len_q;
        heading_d = heading_q;
        hit_d     = 1'b0;
        fail_d    = 1'b0;
        if (tick) begin
            heading_d = heading_next;
            if (collide || (at_edge && !WRAP_EN)) begin
                fail_d = 1'b1;
            end else begin
                for (int i = MAX_LEN - 1; i > 0; i--) seg_d[i] = seg_q[i-1];
                seg_d[0] = new_head;
                if (new_head == target) begin
                    hit_d = 1'b1;
                    if (len_q != LEN_W'(MAX_LEN)) len_d = len_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        on_body = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(len_q)) && (seg_q[i] == pix_cell)) on_body = 1'b1;
        end
        colour_d = COLOUR_IDLE;
        case (game)
            GAME_IDLE: colour_d = COLOUR_IDLE;
            GAME_PLAY: colour_d = on_body ? COLOUR_SNAKE :
                                  (pix_cell == target) ? COLOUR_TARGET : COLOUR_BG;
            GAME_WIN:  colour_d = COLOUR_WIN;
            GAME_LOSE: colour_d = COLOUR_LOSE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) seg_q[i] <= '{x: 7'(START_X - i), y: 6'(START_Y)};
                else              seg_q[i] <= '0;
            end
            len_q     <= LEN_W'(INIT_LEN);
            heading_q <= DIR_RIGHT;
            colour_q  <= COLOUR_IDLE;
            hit_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            seg_q     <= seg_d;
            len_q     <= len_d;
            heading_q <= heading_d;
            colour_q  <= colour_d;
            hit_q     <= hit_d;
            fail_q    <= fail_d;
        end
    end

    assign COLOUR_OUT     = colour_q;
    assign TARGET_REACHED = hit_q;
    assign FAILED         = fail_q;

endmodule

// File: tb/tb_snake_control.sv
// Bench for snake_control with MOVE_PERIOD=4: each step is a group of four play
// cycles, the fourth being the tick; pixel probes expose body state via COLOUR_OUT.
module tb_snake_control;

    localparam int MAX_LEN     = 8;
    localparam int INIT_LEN    = 4;
    localparam int MOVE_PERIOD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  addrh;
    logic [8:0]  addrv;
    logic [1:0]  master_state;
    logic [1:0]  direction;
    logic [6:0]  target_x;
    logic [5:0]  target_y;
    logic [11:0] colour_out;
    logic        target_reached;
    logic        failed;

    snake_control #(
        .MAX_LEN     (MAX_LEN),
        .INIT_LEN    (INIT_LEN),
        .MOVE_PERIOD (MOVE_PERIOD)
    ) dut (
        .CLK            (clk),
        .RESET          (reset),
        .ADDRH          (addrh),
        .ADDRV          (addrv),
        .MASTER_STATE   (master_state),
        .DIRECTION      (direction),
        .TARGET_X       (target_x),
        .TARGET_Y       (target_y),
        .COLOUR_OUT     (colour_out),
        .TARGET_REACHED (target_reached),
        .FAILED         (failed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dir;
        int         tx, ty;
        int         hx, hy;
        int         len;
        bit         hit, fail;
    } step_t;

    step_t       tbl[$];
    logic [11:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference body: one extra entry holds the cell just behind the tail.
    int mx [MAX_LEN+1];
    int my [MAX_LEN+1];
    int mlen;
    int tx, ty;
    logic hit_s, fail_s;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] exp_colour(input int cx, input int cy, input logic [1:0] st);
        if (st == 2'b00) return 12'h000;
        if (st == 2'b10) return 12'h0F0;
        if (st == 2'b11) return 12'hF00;
        for (int i = 0; i < mlen; i++) if (mx[i] == cx && my[i] == cy) return 12'hFF0;
        if (cx == tx && cy == ty) return 12'hF00;
        return 12'h00F;
    endfunction

    function automatic step_t mk(input logic [1:0] dir, input int t_x, input int t_y,
                                 input int hx, input int hy, input int len, input bit hit, input bit fail);
        step_t s;
        s.dir = dir; s.tx = t_x; s.ty = t_y; s.hx = hx; s.hy = hy;
        s.len = len; s.hit = hit; s.fail = fail;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= MAX_LEN; i++) begin
            mx[i] = 40 - i;
            my[i] = 30;
        end
        mlen = INIT_LEN;
    endtask

    // One clock: drive inputs and a probe cell, then check the registered colour.
    task automatic cycle(input logic [1:0] st, input logic [1:0] dir, input int cx, input int cy, input bit rst);
        reset        = rst;
        master_state = st;
        direction    = dir;
        addrh        = 10'(cx * 8 + int'($urandom_range(0, 7)));
        addrv        = 9'(cy * 8 + int'($urandom_range(0, 7)));
        target_x     = 7'(tx);
        target_y     = 6'(ty);
        exp_q.push_back(rst ? 12'h000 : exp_colour(cx, cy, st));
        @(posedge clk);
        #1;
        chk($sformatf("colour(%0d,%0d,st%0d)", cx, cy, st), int'(colour_out), int'(exp_q.pop_front()));
        hit_s  = target_reached;
        fail_s = failed;
    endtask

    task automatic run_step(input int idx, input step_t s);
        int px [4];
        int py [4];
        tx = s.tx;
        ty = s.ty;
        px = '{mx[0], mx[mlen-1], mx[mlen], tx};
        py = '{my[0], my[mlen-1], my[mlen], ty};
        for (int k = 0; k < 4; k++) begin
            cycle(2'b01, s.dir, px[k], py[k], 1'b0);
            if (k < 3) begin
                chk($sformatf("hit_quiet@%0d", idx), int'(hit_s), 0);
                chk($sformatf("fail_quiet@%0d", idx), int'(fail_s), 0);
            end else begin
                chk($sformatf("hit@%0d", idx), int'(hit_s), int'(s.hit));
                chk($sformatf("fail@%0d", idx), int'(fail_s), int'(s.fail));
            end
        end
        if (!s.fail) begin
            for (int i = MAX_LEN; i > 0; i--) begin
                mx[i] = mx[i-1];
                my[i] = my[i-1];
            end
            mx[0] = s.hx;
            my[0] = s.hy;
        end
        mlen = s.len;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hy0;
        logic [1:0] frozen_states [3];

        // Stimulus table: {direction, target, expected head, len, pulses}.
        tbl.push_back(mk(2'b01, 5, 5, 41, 30, 4, 0, 0));
        tbl.push_back(mk(2'b01, 5, 5, 42, 30, 4, 0, 0));
        tbl.push_back(mk(2'b01, 5, 5, 43, 30, 4, 0, 0));
        tbl.push_back(mk(2'b11, 5, 5, 44, 30, 4, 0, 0));
        tbl.push_back(mk(2'b01, 45, 30, 45, 30, 5, 1, 0));
        tbl.push_back(mk(2'b01, 46, 30, 46, 30, 6, 1, 0));
        tbl.push_back(mk(2'b01, 47, 30, 47, 30, 7, 1, 0));
        tbl.push_back(mk(2'b01, 48, 30, 48, 30, 8, 1, 0));
        tbl.push_back(mk(2'b01, 49, 30, 49, 30, 8, 1, 0));
        tbl.push_back(mk(2'b00, 5, 5, 49, 29, 8, 0, 0));
        tbl.push_back(mk(2'b11, 5, 5, 48, 29, 8, 0, 0));
        tbl.push_back(mk(2'b10, 48, 30, 48, 30, 8, 0, 1));
        tbl.push_back(mk(2'b11, 5, 5, 47, 29, 8, 0, 0));
        for (int y = 28; y >= 0; y--) tbl.push_back(mk(2'b00, 5, 5, 47, y, 8, 0, 0));
`ifdef SNAKE_WRAP_EN
        tbl.push_back(mk(2'b00, 5, 5, 47, 59, 8, 0, 0));
        hy0 = 59;
`else
        tbl.push_back(mk(2'b00, 5, 5, 47, 0, 8, 0, 1));
        hy0 = 0;
`endif
        for (int x = 48; x <= 79; x++) tbl.push_back(mk(2'b01, 5, 5, x, hy0, 8, 0, 0));
`ifdef SNAKE_WRAP_EN
        tbl.push_back(mk(2'b01, 5, 5, 0, hy0, 8, 0, 0));
        tbl.push_back(mk(2'b01, 5, 5, 1, hy0, 8, 0, 0));
`else
        tbl.push_back(mk(2'b01, 5, 5, 79, hy0, 8, 0, 1));
        tbl.push_back(mk(2'b01, 5, 5, 79, hy0, 8, 0, 1));
`endif

        tx = 5;
        ty = 5;
        model_reset();
        reset = 1'b1; master_state = 2'b00; direction = 2'b01;
        addrh = '0; addrv = '0; target_x = 7'd5; target_y = 6'd5;

        // Reset state, including reset held while the game is in play.
        cycle(2'b00, 2'b01, 40, 30, 1'b1);
        cycle(2'b01, 2'b01, 40, 30, 1'b1);
        chk("reset_hit", int'(target_reached), 0);
        chk("reset_fail", int'(failed), 0);

        foreach (tbl[i]) run_step(i, tbl[i]);

        // Non-play states: flat colours, no pulses, nothing moves.
        frozen_states = '{2'b00, 2'b10, 2'b11};
        foreach (frozen_states[j]) begin
            for (int k = 0; k < 3; k++) begin
                cycle(frozen_states[j], 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 79)), int'($urandom_range(0, 59)), 1'b0);
                chk("frozen_hit", int'(hit_s), 0);
                chk("frozen_fail", int'(fail_s), 0);
            end
        end
`ifdef SNAKE_WRAP_EN
        run_step(1000, mk(2'b01, 5, 5, 2, hy0, 8, 0, 0));
`else
        run_step(1000, mk(2'b01, 5, 5, 79, hy0, 8, 0, 1));
`endif

        // Reset arriving on the tick cycle overrides the step and its pulses.
        tx = mx[0] + 1;
        ty = my[0];
        for (int k = 0; k < 3; k++) cycle(2'b01, 2'b01, mx[0], my[0], 1'b0);
        cycle(2'b01, 2'b01, mx[0], my[0], 1'b1);
        chk("tick_reset_hit", int'(hit_s), 0);
        chk("tick_reset_fail", int'(fail_s), 0);
        model_reset();
        run_step(2000, mk(2'b01, 5, 5, 41, 30, 4, 0, 0));
        run_step(2001, mk(2'b01, 42, 30, 42, 30, 5, 1, 0));
        run_step(2002, mk(2'b10, 5, 5, 42, 31, 5, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
